// File: rtl/vram_ctrl.sv
// vram_ctrl: one 16-bit word memory shared by video character-slot fetches (always first) and CPU byte accesses.
// Define VRAM_UNALIGNED_EN so an odd video address reads two words; without it each video address costs one read.
module vram_ctrl (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        fetch_stb,
  input  logic [18:0] vram_addr1,
  input  logic [18:0] vram_addr2,
  output logic [15:0] vram_dout1,
  output logic [15:0] vram_dout2,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_V1A  = 3'd1;
  localparam logic [2:0] S_V1B  = 3'd2;
  localparam logic [2:0] S_V2A  = 3'd3;
  localparam logic [2:0] S_V2B  = 3'd4;
  localparam logic [2:0] S_CPU  = 3'd5;

`ifdef VRAM_UNALIGNED_EN
  localparam logic UNALIGNED = 1'b1;
`else
  localparam logic UNALIGNED = 1'b0;
`endif

  logic [2:0]  state_q, state_d;
  logic [18:0] va1_q, va1_d, va2_q, va2_d;
  logic [18:0] pa1_q, pa1_d, pa2_q, pa2_d;
  logic        vpend_q, vpend_d;
  logic        overrun_q, overrun_d;
  logic [15:0] slot1_q, slot1_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] dout1_q, dout1_d, dout2_q, dout2_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [17:0] issue_addr;
  logic [15:0] rdata_swap;

  assign rdata_swap = {mem_rdata[7:0], mem_rdata[15:8]};

  always_comb begin
    issue_addr = cpu_addr[18:1];
    case (state_q)
      S_V1A:   issue_addr = va1_q[18:1];
      S_V1B:   issue_addr = va1_q[18:1] + 18'd1;
      S_V2A:   issue_addr = va2_q[18:1];
      S_V2B:   issue_addr = va2_q[18:1] + 18'd1;
      default: issue_addr = cpu_addr[18:1];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    va1_d       = va1_q;
    va2_d       = va2_q;
    pa1_d       = pa1_q;
    pa2_d       = pa2_q;
    vpend_d     = vpend_q;
    overrun_d   = overrun_q;
    slot1_d     = slot1_q;
    lo_d        = lo_q;
    dout1_d     = dout1_q;
    dout2_d     = dout2_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    // A strobe while busy is parked; hitting a running video slot means that slot is late.
    if (fetch_stb && state_q != S_IDLE) begin
      pa1_d   = vram_addr1;
      pa2_d   = vram_addr2;
      vpend_d = 1'b1;
      if (state_q != S_CPU) overrun_d = 1'b1;
    end

    if (state_q == S_IDLE) begin
      if (fetch_stb) begin
        va1_d   = vram_addr1;
        va2_d   = vram_addr2;
        state_d = S_V1A;
      end else if (vpend_q) begin
        va1_d   = pa1_q;
        va2_d   = pa2_q;
        vpend_d = 1'b0;
        state_d = S_V1A;
      end else if (cpu_req && !cpu_ack_q) begin
        state_d = S_CPU;
      end
    end else if (!mem_req_q) begin
      // Every state issues one cycle after entry, which keeps mem_req low between accesses.
      mem_req_d  = 1'b1;
      mem_addr_d = issue_addr;
      mem_we_d   = (state_q == S_CPU) && cpu_we;
      if (state_q == S_CPU) begin
        mem_be_d    = cpu_addr[0] ? 2'b10 : 2'b01;
        mem_wdata_d = {cpu_din, cpu_din};
      end else begin
        mem_be_d = 2'b11;
      end
    end else if (mem_ack) begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      case (state_q)
        S_V1A: begin
          if (UNALIGNED && va1_q[0]) begin
            lo_d    = mem_rdata[15:8];
            state_d = S_V1B;
          end else begin
            slot1_d = va1_q[0] ? rdata_swap : mem_rdata;
            state_d = S_V2A;
          end
        end
        S_V1B: begin
          slot1_d = {mem_rdata[7:0], lo_q};
          state_d = S_V2A;
        end
        S_V2A: begin
          if (UNALIGNED && va2_q[0]) begin
            lo_d    = mem_rdata[15:8];
            state_d = S_V2B;
          end else begin
            dout1_d = slot1_q;
            dout2_d = va2_q[0] ? rdata_swap : mem_rdata;
            state_d = S_IDLE;
          end
        end
        S_V2B: begin
          dout1_d = slot1_q;
          dout2_d = {mem_rdata[7:0], lo_q};
          state_d = S_IDLE;
        end
        S_CPU: begin
          if (!cpu_we) cpu_dout_d = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
          cpu_ack_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      va1_q       <= '0;
      va2_q       <= '0;
      pa1_q       <= '0;
      pa2_q       <= '0;
      vpend_q     <= 1'b0;
      overrun_q   <= 1'b0;
      slot1_q     <= '0;
      lo_q        <= '0;
      dout1_q     <= '0;
      dout2_q     <= '0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      va1_q       <= va1_d;
      va2_q       <= va2_d;
      pa1_q       <= pa1_d;
      pa2_q       <= pa2_d;
      vpend_q     <= vpend_d;
      overrun_q   <= overrun_d;
      slot1_q     <= slot1_d;
      lo_q        <= lo_d;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign vram_dout1 = dout1_q;
  assign vram_dout2 = dout2_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Bench for vram_ctrl: byte-level reference memory, latency-programmable memory responder, directed and random traffic.
module tb_vram_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        fetch_stb;
  logic [18:0] vram_addr1, vram_addr2;
  logic [15:0] vram_dout1, vram_dout2;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        mem_req, mem_we;
  logic [17:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        overrun;

  vram_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .fetch_stb(fetch_stb),
    .vram_addr1(vram_addr1), .vram_addr2(vram_addr2),
    .vram_dout1(vram_dout1), .vram_dout2(vram_dout2),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word store seen by the DUT, and an independent byte-addressed reference.
  logic [15:0] words [0:262143];
  logic [7:0]  ref_b [int];
  int          lat = 2;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + (a >>> 9) + 5);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [18:0] a);
    if (ref_b.exists(int'(a))) return ref_b[int'(a)];
    return init_byte(int'(a));
  endfunction

  function automatic logic [15:0] exp_fetch(input logic [18:0] a);
`ifdef VRAM_UNALIGNED_EN
    return {ref_byte(19'(a + 19'd1)), ref_byte(a)};
`else
    return {ref_byte(a ^ 19'd1), ref_byte(a)};
`endif
  endfunction

  function automatic int n_access(input logic [18:0] a1, input logic [18:0] a2);
`ifdef VRAM_UNALIGNED_EN
    return (a1[0] ? 2 : 1) + (a2[0] ? 2 : 1);
`else
    return 2;
`endif
  endfunction

  task automatic set_word(input int w, input logic [15:0] v);
    words[w] = v;
    ref_b[2 * w]     = v[7:0];
    ref_b[2 * w + 1] = v[15:8];
  endtask

  // Memory responder: ack L cycles after mem_req rises; counts handshake violations.
  int          cnt;
  logic        acked;
  logic [36:0] snap;
  int          viol = 0;
  logic [1:0]  last_be;
  logic [15:0] last_wd;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      cnt       <= 0;
      acked     <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      if (!mem_req) begin
        cnt   <= 0;
        acked <= 1'b0;
      end else if (acked) begin
        if (!mem_ack) viol <= viol + 1;
      end else begin
        if (cnt == 0) snap <= {mem_addr, mem_we, mem_be, mem_wdata};
        else if (snap != {mem_addr, mem_we, mem_be, mem_wdata}) viol <= viol + 1;
        if (cnt + 1 >= lat) begin
          mem_ack   <= 1'b1;
          acked     <= 1'b1;
          mem_rdata <= words[mem_addr];
          if (mem_we) begin
            if (mem_be[0]) words[mem_addr][7:0]  = mem_wdata[7:0];
            if (mem_be[1]) words[mem_addr][15:8] = mem_wdata[15:8];
            last_be <= mem_be;
            last_wd <= mem_wdata;
          end
        end
        cnt <= cnt + 1;
      end
    end
  end

  logic [15:0] prev1 = '0, prev2 = '0;

  task automatic cpu_op(input logic we, input logic [18:0] a, input logic [7:0] d,
                        output logic [7:0] q, output int acks);
    @(posedge clk_sys); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    acks = 0; q = 'x;
    for (int i = 0; i < 200 && acks == 0; i++) begin
      @(posedge clk_sys); #1;
      if (cpu_ack) begin acks++; q = cpu_dout; end
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); #1;
      if (cpu_ack) acks++;
    end
  endtask

  task automatic video(input logic [18:0] a1, input logic [18:0] a2, input string tag);
    logic [15:0] e1, e2;
    int commit;
    e1 = exp_fetch(a1);
    e2 = exp_fetch(a2);
    commit = n_access(a1, a2) * (lat + 2) + 1;
    @(posedge clk_sys); #1;
    fetch_stb = 1'b1; vram_addr1 = a1; vram_addr2 = a2;
    for (int c = 1; c <= commit; c++) begin
      @(posedge clk_sys); #1;
      if (c == 1) fetch_stb = 1'b0;
      if (c == commit - 1) begin
        chk({tag, "_hold1"}, 32'(vram_dout1), 32'(prev1));
        chk({tag, "_hold2"}, 32'(vram_dout2), 32'(prev2));
      end
    end
    chk({tag, "_d1"}, 32'(vram_dout1), 32'(e1));
    chk({tag, "_d2"}, 32'(vram_dout2), 32'(e2));
    prev1 = e1;
    prev2 = e2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),    0);
    chk({tag, "_mem_we"},    32'(mem_we),     0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),    0);
    chk({tag, "_overrun"},   32'(overrun),    0);
    chk({tag, "_dout1"},     32'(vram_dout1), 0);
    chk({tag, "_dout2"},     32'(vram_dout2), 0);
    chk({tag, "_cpu_dout"},  32'(cpu_dout),   0);
    chk({tag, "_mem_addr"},  32'(mem_addr),   0);
    chk({tag, "_mem_be"},    32'(mem_be),     0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata),  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q;
    int          acks, ack_cyc, first_addr;
    logic [15:0] e1, e2, f1, f2;
    logic [18:0] a1, a2, a;

    for (int w = 0; w < 262144; w++) words[w] = {init_byte(2 * w + 1), init_byte(2 * w)};
    reset = 1'b1; fetch_stb = 1'b0; vram_addr1 = '0; vram_addr2 = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (3) @(posedge clk_sys);
    #1 check_zero("rst");
    reset = 1'b0;

    // Aligned pair, L = 2: commit exactly 9 cycles after the strobe.
    lat = 2;
    set_word(18'h00080, 16'h1234);
    set_word(18'h01080, 16'hABCD);
    video(19'h00100, 19'h02100, "aligned");
    chk("aligned_lit1", 32'(vram_dout1), 32'h1234);
    chk("aligned_lit2", 32'(vram_dout2), 32'hABCD);

    // Odd address at the top of memory wraps to word 0.
    set_word(18'h3FFFF, 16'hAA55);
    set_word(18'h00000, 16'h33CC);
    video(19'h7FFFF, 19'h00000, "wrap");

    // CPU byte write to an odd address, then read back.
    cpu_op(1'b1, 19'h00003, 8'h5A, q, acks);
    ref_b[3] = 8'h5A;
    chk("cpuwr_acks", 32'(acks), 1);
    chk("cpuwr_be", 32'(last_be), 32'h2);
    chk("cpuwr_wdata", 32'(last_wd), 32'h5A5A);
    cpu_op(1'b0, 19'h00003, 8'h00, q, acks);
    chk("cpurd_acks", 32'(acks), 1);
    chk("cpurd_data", 32'(q), 32'h5A);

    // CPU request and strobe together: video goes first, CPU ack after commit.
    set_word(18'h00080, 16'h1111);
    set_word(18'h01080, 16'h2222);
    @(posedge clk_sys); #1;
    fetch_stb = 1'b1; vram_addr1 = 19'h00100; vram_addr2 = 19'h02100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00003;
    ack_cyc = -1; first_addr = -1; acks = 0; q = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_sys); #1;
      if (c == 1) fetch_stb = 1'b0;
      if (mem_req && first_addr < 0) first_addr = int'(mem_addr);
      if (c == 8) chk("coll_hold1", 32'(vram_dout1), 32'(prev1));
      if (c == 9) begin
        chk("coll_d1", 32'(vram_dout1), 32'h1111);
        chk("coll_d2", 32'(vram_dout2), 32'h2222);
      end
      if (cpu_ack) begin
        acks++;
        if (ack_cyc < 0) begin ack_cyc = c; q = cpu_dout; end
        cpu_req = 1'b0;
      end
    end
    prev1 = 16'h1111; prev2 = 16'h2222;
    chk("coll_first_is_video", 32'(first_addr), 32'h80);
    chk("coll_ack_after_commit", 32'(ack_cyc > 9), 1);
    chk("coll_acks", 32'(acks), 1);
    chk("coll_cpu_data", 32'(q), 32'h5A);

    // Second strobe mid-slot with L = 30: first slot commits, second follows, overrun sticks.
    lat = 30;
    set_word(18'h02000, 16'h0F0F);
    set_word(18'h02001, 16'hF0F0);
    set_word(18'h00080, 16'h4444);
    set_word(18'h01080, 16'h5555);
    e1 = exp_fetch(19'h00100); e2 = exp_fetch(19'h02100);
    f1 = exp_fetch(19'h04000); f2 = exp_fetch(19'h04002);
    @(posedge clk_sys); #1;
    fetch_stb = 1'b1; vram_addr1 = 19'h00100; vram_addr2 = 19'h02100;
    for (int c = 1; c <= 130; c++) begin
      @(posedge clk_sys); #1;
      fetch_stb = 1'b0;
      if (c == 19) chk("ovr_before", 32'(overrun), 0);
      if (c == 20) begin fetch_stb = 1'b1; vram_addr1 = 19'h04000; vram_addr2 = 19'h04002; end
      if (c == 21) chk("ovr_set", 32'(overrun), 1);
      if (c == 64) chk("ovr_hold", 32'(vram_dout1), 32'(prev1));
      if (c == 65) begin
        chk("ovr_slot1_d1", 32'(vram_dout1), 32'(e1));
        chk("ovr_slot1_d2", 32'(vram_dout2), 32'(e2));
      end
      if (c == 129) chk("ovr_slot1_kept", 32'(vram_dout1), 32'(e1));
    end
    chk("ovr_slot2_d1", 32'(vram_dout1), 32'(f1));
    chk("ovr_slot2_d2", 32'(vram_dout2), 32'(f2));
    chk("ovr_sticky", 32'(overrun), 1);
    prev1 = f1; prev2 = f2;

    // Reset in the middle of a CPU write: everything clears without waiting for a clock.
    lat = 8;
    @(posedge clk_sys); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_din = 8'hEE;
    repeat (4) @(posedge clk_sys);
    #1 chk("midrst_req_high", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    cpu_req = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    prev1 = '0; prev2 = '0;
    cpu_op(1'b0, 19'h00010, 8'h00, q, acks);
    chk("postrst_acks", 32'(acks), 1);
    chk("postrst_data", 32'(q), 32'(ref_byte(19'h00010)));

    // Random traffic against the byte reference.
    for (int it = 0; it < 40; it++) begin
      lat = int'($urandom_range(1, 8));
      case ($urandom_range(0, 3))
        0: begin
          a = 19'($urandom);
          cpu_op(1'b0, a, 8'h00, q, acks);
          chk("rnd_rd_acks", 32'(acks), 1);
          chk("rnd_rd_data", 32'(q), 32'(ref_byte(a)));
        end
        1: begin
          a = 19'($urandom);
          cpu_op(1'b1, a, 8'($urandom), q, acks);
          ref_b[int'(a)] = cpu_din;
          chk("rnd_wr_acks", 32'(acks), 1);
        end
        default: begin
          a1 = 19'($urandom);
          a2 = 19'($urandom);
          if ($urandom_range(0, 3) == 0) a1 = 19'h7FFFF;
          video(a1, a2, "rnd_vid");
        end
      endcase
    end

    chk("mem_protocol", 32'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
